// File: rtl/serial2parallel.sv
// Serial-to-parallel converter: rebuilds WIDTH-bit words from a sync-aligned bit stream.
// Optional macro S2P_LSB_FIRST_EN selects LSB-first word assembly (default MSB-first).
module serial2parallel #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             serial_sig,
    input  logic             sync_sig,
    output logic [WIDTH-1:0] parallel_sig,
    output logic             valid_sig,
    output logic             locked_sig,
    output logic             align_err_sig
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_done;
    logic [WIDTH-1:0] r_par;
    logic             r_valid;
    logic             r_err;

    logic [WIDTH-1:0] w_first_word;
    logic [WIDTH-1:0] w_shifted;

`ifdef S2P_LSB_FIRST_EN
    // First bit enters at the top and walks down to bit 0 by the end of the word.
    assign w_first_word = {serial_sig, {(WIDTH-1){1'b0}}};
    assign w_shifted    = {serial_sig, r_shift[WIDTH-1:1]};
`else
    assign w_first_word = {{(WIDTH-1){1'b0}}, serial_sig};
    assign w_shifted    = {r_shift[WIDTH-2:0], serial_sig};
`endif

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_par   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // A word completed last edge is published one clock after its last bit.
            r_valid <= r_done;
            if (r_done)
                r_par <= r_shift;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                HUNT: begin
                    if (sync_sig) begin
                        r_shift <= w_first_word;
                        r_cnt   <= ONE;
                        r_state <= RUN;
                    end
                end
                default: begin
                    if (sync_sig && (r_cnt != '0)) begin
                        r_shift <= w_first_word;
                        r_cnt   <= ONE;
                        r_err   <= 1'b1;
                    end else begin
                        r_shift <= (r_cnt == '0) ? w_first_word : w_shifted;
                        if (r_cnt == LAST) begin
                            r_cnt  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign parallel_sig  = r_par;
    assign valid_sig     = r_valid;
    assign locked_sig    = (r_state == RUN);
    assign align_err_sig = r_err;

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: WIDTH=2 and WIDTH=4 instances share one stimulus stream.
module tb_serial2parallel;

    logic       clk_sig = 1'b0;
    logic       reset_sig = 1'b1;
    logic       serial_sig = 1'b0;
    logic       sync_sig = 1'b0;

    logic [1:0] par2;
    logic       valid2, locked2, err2;
    logic [3:0] par4;
    logic       valid4, locked4, err4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sig = ~clk_sig;

    serial2parallel #(.WIDTH(2)) u_dut2 (
        .clk_sig      (clk_sig),
        .reset_sig    (reset_sig),
        .serial_sig   (serial_sig),
        .sync_sig     (sync_sig),
        .parallel_sig (par2),
        .valid_sig    (valid2),
        .locked_sig   (locked2),
        .align_err_sig(err2)
    );

    serial2parallel #(.WIDTH(4)) u_dut4 (
        .clk_sig      (clk_sig),
        .reset_sig    (reset_sig),
        .serial_sig   (serial_sig),
        .sync_sig     (sync_sig),
        .parallel_sig (par4),
        .valid_sig    (valid4),
        .locked_sig   (locked4),
        .align_err_sig(err4)
    );

    // Expected words are written MSB-first (first bit leftmost); LSB-first builds reverse them.
    function automatic logic [3:0] ord4(input logic [3:0] m);
`ifdef S2P_LSB_FIRST_EN
        return {m[0], m[1], m[2], m[3]};
`else
        return m;
`endif
    endfunction

    function automatic logic [1:0] ord2(input logic [1:0] m);
`ifdef S2P_LSB_FIRST_EN
        return {m[0], m[1]};
`else
        return m;
`endif
    endfunction

    task automatic step(input logic s, input logic d);
        sync_sig   = s;
        serial_sig = d;
        @(posedge clk_sig);
        #2;
    endtask

    task automatic do_reset();
        reset_sig  = 1'b1;
        sync_sig   = 1'b0;
        serial_sig = 1'b0;
        @(posedge clk_sig);
        #2;
        reset_sig = 1'b0;
    endtask

    task automatic test_reset();
        reset_sig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sig);
            #2;
            n_checks++;
            if ({par2, valid2, locked2, err2} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: par=%b v=%b l=%b e=%b, required all 0", i, par2, valid2, locked2, err2);
            end
        end
        reset_sig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            n_checks++;
            if ({par2, valid2, locked2, err2, par4, valid4, locked4, err4} !== 12'b0) begin
                n_fail++;
                $display("FAIL hunt_idle cyc%0d: w2 %b/%b/%b/%b w4 %h/%b/%b/%b, required all 0",
                         i, par2, valid2, locked2, err2, par4, valid4, locked4, err4);
            end
        end
    endtask

    task automatic test_width2_stream();
        logic [1:0] seq_s [7];
        logic [1:0] seq_d [7];
        logic       exp_v [7];
        logic [1:0] exp_p [7];
        do_reset();
        seq_s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_p = '{2'b00, 2'b00, ord2(2'b10), ord2(2'b10), ord2(2'b11), ord2(2'b11), ord2(2'b01)};
        for (int i = 0; i < 7; i++) begin
            step(seq_s[i][0], seq_d[i][0]);
            n_checks++;
            if (locked2 !== 1'b1) begin
                n_fail++;
                $display("FAIL w2_locked step%0d: got %b, required 1", i, locked2);
            end
            n_checks++;
            if (valid2 !== exp_v[i] || par2 !== exp_p[i] || err2 !== 1'b0) begin
                n_fail++;
                $display("FAIL w2_word step%0d: v=%b par=%b e=%b, required v=%b par=%b e=0",
                         i, valid2, par2, err2, exp_v[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        do_reset();
        bits = 8'b1011_0110;
        for (int i = 0; i < 12; i++) begin
            if (i < 8)
                step((i == 0 || i == 4) ? 1'b1 : 1'b0, bits[7-i]);
            else
                step(1'b0, 1'b0);
            n_checks++;
            if (valid4 !== ((i == 4) || (i == 8)) || err4 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_valid step%0d: v=%b e=%b, required v=%b e=0", i, valid4, err4, (i == 4) || (i == 8));
            end
            if (i == 4 || i == 8) begin
                n_checks++;
                if (par4 !== ((i == 4) ? ord4(4'hB) : ord4(4'h6))) begin
                    n_fail++;
                    $display("FAIL b2b_word step%0d: got %h, required %h", i, par4, (i == 4) ? ord4(4'hB) : ord4(4'h6));
                end
            end
        end
    endtask

    task automatic test_misalign();
        int n_err = 0;
        int n_val = 0;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_checks++;
        if (err4 !== 1'b1 || valid4 !== 1'b0 || locked4 !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_err: e=%b v=%b l=%b, required e=1 v=0 l=1", err4, valid4, locked4);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (err4 !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: e=%b one cycle later, required 0", err4);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        n_checks++;
        if (valid4 !== 1'b0 || par4 !== 4'h0) begin
            n_fail++;
            $display("FAIL misalign_partial: v=%b par=%h, required v=0 par=0", valid4, par4);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (valid4 !== 1'b1 || par4 !== ord4(4'h3)) begin
            n_fail++;
            $display("FAIL misalign_word: v=%b par=%h, required v=1 par=%h", valid4, par4, ord4(4'h3));
        end
        // Sync on the last bit slot is also a misalignment: word dropped, error flagged.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (err4) n_err++;
            if (valid4) n_val++;
            step(1'b0, 1'b0);
        end
        n_checks++;
        if (n_err != 1 || n_val != 0) begin
            n_fail++;
            $display("FAIL misalign_last: err pulses=%0d valid pulses=%0d, required 1 and 0", n_err, n_val);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] w;
        do_reset();
        w = 4'b1011;
        for (int i = 0; i < 4; i++) step(i == 0, w[3-i]);
        step(1'b0, 1'b0);
        n_checks++;
        if (valid4 !== 1'b1 || par4 !== ord4(4'hB)) begin
            n_fail++;
            $display("FAIL rst_pre_word: v=%b par=%h, required v=1 par=%h", valid4, par4, ord4(4'hB));
        end
        step(1'b0, 1'b1);
        reset_sig = 1'b1;
        step(1'b0, 1'b0);
        reset_sig = 1'b0;
        n_checks++;
        if (valid4 !== 1'b0 || locked4 !== 1'b0 || par4 !== 4'h0 || err4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: v=%b l=%b par=%h e=%b, required all 0", valid4, locked4, par4, err4);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (valid4 !== 1'b0 || locked4 !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_hunt step%0d: v=%b l=%b, required 0 0", i, valid4, locked4);
            end
        end
        w = 4'b1001;
        for (int i = 0; i < 4; i++) step(i == 0, w[3-i]);
        step(1'b0, 1'b0);
        n_checks++;
        if (valid4 !== 1'b1 || par4 !== ord4(4'h9) || locked4 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resume: v=%b par=%h l=%b, required v=1 par=%h l=1", valid4, par4, locked4, ord4(4'h9));
        end
    endtask

    task automatic test_bit_order();
        logic [3:0] expw;
`ifdef S2P_LSB_FIRST_EN
        expw = 4'h1;
`else
        expw = 4'h8;
`endif
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (valid4 !== 1'b1 || par4 !== expw) begin
            n_fail++;
            $display("FAIL bit_order: v=%b par=%h, required v=1 par=%h", valid4, par4, expw);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (valid4 !== 1'b0 || par4 !== expw) begin
            n_fail++;
            $display("FAIL hold_word: v=%b par=%h, required v=0 par=%h", valid4, par4, expw);
        end
    endtask

    initial begin
        test_reset();
        test_width2_stream();
        test_back_to_back();
        test_misalign();
        test_reset_midword();
        test_bit_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
